// File: rtl/rx_pixel_cmd.sv
// rx_pixel_cmd: turns UART bytes into pixel-buffer writes and strip show requests.
module rx_pixel_cmd #(
  parameter int          NUM_PIXELS   = 8,
  parameter int          TIMEOUT_CLKS = 12000,
  parameter logic [7:0]  CMD_SET      = 8'hA5,
  parameter logic [7:0]  CMD_SHOW     = 8'h5A
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  input  logic        i_strip_busy,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [23:0] o_wr_data,
  output logic        o_show,
  output logic        o_err,
  output logic        o_busy
);
  localparam int CW = $clog2(TIMEOUT_CLKS);
  typedef enum logic [2:0] {IDLE, GET_IDX, GET_G, GET_R, GET_B, SHOW_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d, g_q, g_d, r_q, r_d, wr_addr_q, wr_addr_d;
  logic [23:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, show_q, show_d, err_q, err_d, in_pkt;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    g_d       = g_q;
    r_d       = r_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    show_d    = 1'b0;
    err_d     = 1'b0;
    in_pkt    = state_q inside {GET_IDX, GET_G, GET_R, GET_B};
    if (in_pkt) cnt_d = i_rx_valid ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (i_rx_valid) begin
        if (i_rx_byte == CMD_SET) begin
          state_d = GET_IDX;
          cnt_d   = '0;
        end else if (i_rx_byte == CMD_SHOW) begin
          state_d = i_strip_busy ? SHOW_WAIT : IDLE;
          show_d  = ~i_strip_busy;
        end
      end
      GET_IDX: if (i_rx_valid) begin
        idx_d   = i_rx_byte;
        state_d = GET_G;
      end
      GET_G: if (i_rx_valid) begin
        g_d     = i_rx_byte;
        state_d = GET_R;
      end
      GET_R: if (i_rx_valid) begin
        r_d     = i_rx_byte;
        state_d = GET_B;
      end
      GET_B: if (i_rx_valid) begin
        state_d = IDLE;
        if ({24'd0, idx_q} < 32'(NUM_PIXELS)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {g_q, r_q, i_rx_byte};
        end else err_d = 1'b1;
      end
      SHOW_WAIT: if (i_rx_valid) err_d = 1'b1;
      else if (!i_strip_busy) begin
        show_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a byte in the timeout cycle wins, so only abort when nothing arrived
    if (in_pkt && !i_rx_valid && cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      g_q       <= '0;
      r_q       <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      show_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      g_q       <= g_d;
      r_q       <= r_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      show_q    <= show_d;
      err_q     <= err_d;
    end
  end
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_show    = show_q;
  assign o_err     = err_q;
  assign o_busy    = state_q != IDLE;
endmodule

// File: tb/tb_rx_pixel_cmd.sv
// tb_rx_pixel_cmd: packet-level model compared every cycle, plus directed literal checks.
module tb_rx_pixel_cmd;
  localparam int NP = 8;
  localparam int TO = 12000;
  logic clk = 1'b0, i_reset = 1'b1, i_rx_valid = 1'b0, i_strip_busy = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic o_wr_en, o_show, o_err, o_busy;
  logic [7:0] o_wr_addr;
  logic [23:0] o_wr_data;
  int vectors = 0, miscompares = 0;
  rx_pixel_cmd #(.NUM_PIXELS(NP), .TIMEOUT_CLKS(TO), .CMD_SET(8'hA5), .CMD_SHOW(8'h5A)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
    .i_strip_busy(i_strip_busy), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_show(o_show), .o_err(o_err), .o_busy(o_busy));
  always #5 clk = ~clk;
  logic [7:0] pkt[$];
  bit pend = 0, m_wr = 0, m_err = 0, m_show = 0, started = 0;
  logic [7:0] m_addr = 0;
  logic [23:0] m_data = 0;
  int gap = 0;
  always @(posedge clk) begin
    started = 1;
    m_wr = 0;
    m_err = 0;
    m_show = 0;
    if (i_reset) begin
      pkt.delete();
      pend = 0;
      gap = 0;
      m_addr = 0;
      m_data = 0;
    end else if (pend) begin
      if (i_rx_valid) m_err = 1;
      else if (!i_strip_busy) begin
        m_show = 1;
        pend = 0;
      end
    end else if (pkt.size() == 0) begin
      if (i_rx_valid && i_rx_byte == 8'hA5) begin
        pkt.push_back(i_rx_byte);
        gap = 0;
      end else if (i_rx_valid && i_rx_byte == 8'h5A) begin
        if (i_strip_busy) pend = 1;
        else m_show = 1;
      end
    end else if (i_rx_valid) begin
      pkt.push_back(i_rx_byte);
      gap = 0;
      if (pkt.size() == 5) begin
        if (int'(pkt[1]) < NP) begin
          m_wr = 1;
          m_addr = pkt[1];
          m_data = {pkt[2], pkt[3], pkt[4]};
        end else m_err = 1;
        pkt.delete();
      end
    end else if (gap == TO - 1) begin
      m_err = 1;
      pkt.delete();
    end else gap++;
  end
  int wr_tot = 0, err_tot = 0, show_tot = 0;
  logic [7:0] last_addr = 0;
  logic [23:0] last_data = 0;
  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_tot++;
      last_addr = o_wr_addr;
      last_data = o_wr_data;
    end
    if (o_err) err_tot++;
    if (o_show) show_tot++;
    if (started) begin
      vectors++;
      if ({o_wr_en, o_wr_addr, o_wr_data, o_show, o_err, o_busy} !==
          {m_wr, m_addr, m_data, m_show, m_err, pkt.size() != 0 || pend}) begin
        miscompares++;
        $display("FAIL model t=%0t dut wr=%b a=%h d=%h sh=%b er=%b bz=%b required wr=%b a=%h d=%h sh=%b er=%b bz=%b",
                 $time, o_wr_en, o_wr_addr, o_wr_data, o_show, o_err, o_busy,
                 m_wr, m_addr, m_data, m_show, m_err, pkt.size() != 0 || pend);
      end
    end
  end
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_byte = b;
    tick(1);
    i_rx_valid = 1'b0;
  endtask
  int w0, e0, s0, n;
  initial begin
    tick(3);
    check("reset_outs", {o_wr_en, o_wr_addr, o_wr_data, o_show, o_err, o_busy}, 0);
    i_reset = 1'b0;
    tick(2);
    w0 = wr_tot; e0 = err_tot;
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    check("wr_latency", o_wr_en, 1);
    check("wr_addr", o_wr_addr, 3);
    check("wr_data", o_wr_data, 24'h102030);
    tick(2);
    check("wr_count", wr_tot - w0, 1);
    check("wr_no_err", err_tot - e0, 0);
    check("addr_hold", o_wr_addr, 3);
    w0 = wr_tot; e0 = err_tot;
    send(8'hA5); send(8'h08); send(8'hFF); send(8'hFF); send(8'hFF);
    tick(2);
    check("oor_no_wr", wr_tot - w0, 0);
    check("oor_err", err_tot - e0, 1);
    check("oor_idle", o_busy, 0);
    e0 = err_tot;
    send(8'hA5); send(8'h02); send(8'h11);
    n = 0;
    while (!o_err && n < TO + 1000) begin
      tick(1);
      n++;
    end
    check("timeout_clks", n, TO);
    check("timeout_busy", o_busy, 0);
    tick(2);
    check("timeout_err_once", err_tot - e0, 1);
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    tick(1);
    check("post_to_addr", last_addr, 1);
    check("post_to_data", last_data, 24'hAABBCC);
    s0 = show_tot; e0 = err_tot;
    i_strip_busy = 1'b1;
    send(8'h5A);
    tick(3);
    check("showwait_noshow", show_tot - s0, 0);
    check("showwait_busy", o_busy, 1);
    send(8'h00);
    tick(1);
    check("showwait_err", err_tot - e0, 1);
    i_strip_busy = 1'b0;
    tick(3);
    check("showwait_show", show_tot - s0, 1);
    check("showwait_idle", o_busy, 0);
    s0 = show_tot; e0 = err_tot;
    send(8'h00); send(8'hFF); send(8'h5A);
    check("show_latency", o_show, 1);
    tick(2);
    check("show_once", show_tot - s0, 1);
    check("show_no_err", err_tot - e0, 0);
    send(8'hA5); send(8'h04); send(8'h01);
    i_reset = 1'b1;
    tick(1);
    check("midreset_outs", {o_wr_en, o_wr_addr, o_wr_data, o_show, o_err, o_busy}, 0);
    i_reset = 1'b0;
    w0 = wr_tot; e0 = err_tot;
    send(8'h10); send(8'h20);
    tick(3);
    check("postreset_no_wr", wr_tot - w0, 0);
    check("postreset_no_err", err_tot - e0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
